// File: rtl/gpr_multiport_sb.sv
// Multi-read-port general-purpose register file with byte-lane writes and a pending-write scoreboard.
// Define GPR_BYPASS_EN to forward same-cycle write-back data and busy clears to the read ports.
module gpr_multiport_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_byte_en,
    input  logic                           issue_en,
    input  logic [ADDR_WIDTH-1:0]          issue_addr,
    output logic [2**ADDR_WIDTH-1:0]       busy_vec,
    output logic [ADDR_WIDTH:0]            busy_cnt,
    output logic                           sb_full
);

    localparam int NUM_REGS  = 2**ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_REGS - 1);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;
    logic [CNT_W-1:0]      r_busy_cnt;
    logic                  r_sb_full;

    logic                  w_wr_valid;
    logic                  w_issue_valid;
    logic                  w_same_reg;
    logic [DATA_WIDTH-1:0] w_wr_mask;
    logic [NUM_REGS-1:0]   w_busy_next;
    logic                  w_cnt_inc;
    logic                  w_cnt_dec;
    logic [CNT_W-1:0]      w_cnt_next;

    // Register 0 is hard-wired to zero, so neither path may touch it; reset blocks both.
    assign w_wr_valid    = wr_en && !reset && (wr_addr != '0);
    assign w_issue_valid = issue_en && !reset && (issue_addr != '0);
    assign w_same_reg    = w_wr_valid && w_issue_valid && (wr_addr == issue_addr);

    always_comb begin
        w_wr_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_wr_mask[i*8 +: 8] = {8{wr_byte_en[i]}};
        end
    end

    // NOTE: every register is a flop cleared by reset because the array must be all-zero
    // one cycle after reset; a RAM macro without a clear port could not provide that.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_wr_valid) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values,
            // independent of the order the simulator evaluates processes.
            r_regs[wr_addr] <= (r_regs[wr_addr] & ~w_wr_mask) | (wr_data & w_wr_mask);
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_valid) begin
            w_busy_next[wr_addr] = 1'b0;
        end
        if (w_issue_valid) begin
            w_busy_next[issue_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Count is tracked by transitions; set and clear on one register nets to "stays busy".
    assign w_cnt_inc = w_issue_valid && !r_busy[issue_addr];
    assign w_cnt_dec = w_wr_valid && r_busy[wr_addr] && !w_same_reg;

    always_comb begin
        w_cnt_next = r_busy_cnt;
        case ({w_cnt_inc, w_cnt_dec})
            2'b10:   w_cnt_next = r_busy_cnt + CNT_W'(1);
            2'b01:   w_cnt_next = r_busy_cnt - CNT_W'(1);
            default: w_cnt_next = r_busy_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_sb_full  <= 1'b0;
        end else begin
            r_busy     <= w_busy_next;
            r_busy_cnt <= w_cnt_next;
            r_sb_full  <= (w_cnt_next == FULL_CNT);
        end
    end

    assign busy_vec = r_busy;
    assign busy_cnt = r_busy_cnt;
    assign sb_full  = r_sb_full;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_stored;

        assign w_addr   = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_stored = (w_addr == '0) ? '0 : r_regs[w_addr];

`ifdef GPR_BYPASS_EN
        logic w_hit;
        logic w_reissue;

        assign w_hit     = w_wr_valid && (wr_addr == w_addr);
        assign w_reissue = w_issue_valid && (issue_addr == w_addr);
        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
            w_hit ? ((w_stored & ~w_wr_mask) | (wr_data & w_wr_mask)) : w_stored;
        assign rd_busy[k] = (w_hit && !w_reissue) ? 1'b0 : r_busy[w_addr];
`else
        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_stored;
        assign rd_busy[k]                          = r_busy[w_addr];
`endif
    end

endmodule

// File: tb/tb_gpr_multiport_sb.sv
// Self-checking bench for gpr_multiport_sb: directed scenarios plus randomized traffic
// compared against an array/bit-vector reference model of the register file and scoreboard.
module tb_gpr_multiport_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NREGS = 32;
    localparam int NL    = DW / 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NL-1:0]    wr_byte_en;
    logic             issue_en;
    logic [AW-1:0]    issue_addr;
    logic [NREGS-1:0] busy_vec;
    logic [AW:0]      busy_cnt;
    logic             sb_full;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] m_regs [NREGS];
    bit            m_busy [NREGS];

    gpr_multiport_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_byte_en (wr_byte_en),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy_vec   (busy_vec),
        .busy_cnt   (busy_cnt),
        .sb_full    (sb_full)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] lane_merge(logic [DW-1:0] old_v, logic [DW-1:0] new_v,
                                                 logic [NL-1:0] be);
        logic [DW-1:0] res;
        res = old_v;
        for (int i = 0; i < NL; i++) begin
            if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return res;
    endfunction

    function automatic int model_cnt();
        int c;
        c = 0;
        for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    function automatic logic [NREGS-1:0] model_vec();
        logic [NREGS-1:0] v;
        for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_rd(int k);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = rd_addr[k*AW +: AW];
        if (a == 0) return '0;
        v = m_regs[a];
`ifdef GPR_BYPASS_EN
        if (!reset && wr_en && wr_addr == a) v = lane_merge(v, wr_data, wr_byte_en);
`endif
        return v;
    endfunction

    function automatic logic exp_rbusy(int k);
        logic [AW-1:0] a;
        logic b;
        a = rd_addr[k*AW +: AW];
        b = m_busy[a];
`ifdef GPR_BYPASS_EN
        if (!reset && wr_en && a != 0 && wr_addr == a && !(issue_en && issue_addr == a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = lane_merge(m_regs[wr_addr], wr_data, wr_byte_en);
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        wr_en    = 1'b0;
        issue_en = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 5'd5;
        wr_data    = $urandom;
        wr_byte_en = 4'hF;
        issue_en   = 1'b1;
        issue_addr = 5'd6;
        tick();
        idle();
        rd_addr = {5'd6, 5'd5};
        #1;
        n_cmp++;
        if (rd_data !== '0) begin
            n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        n_cmp++;
        if (busy_vec !== '0 || busy_cnt !== '0 || sb_full !== 1'b0) begin
            n_err++; $display("FAIL reset_sb: got vec=%h cnt=%0d full=%b want 0/0/0",
                              busy_vec, busy_cnt, sb_full);
        end
    endtask

    task automatic test_basic_write();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_byte_en = 4'hF;
        issue_en = 1'b1; issue_addr = 5'd8;
        tick();
        idle();
        rd_addr = {5'd8, 5'd5};
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL basic_read: got %h want deadbeef", rd_data[31:0]);
        end
        n_cmp++;
        if (busy_cnt !== 6'd1 || rd_busy !== 2'b10) begin
            n_err++; $display("FAIL basic_busy: got cnt=%0d rd_busy=%b want 1/10", busy_cnt, rd_busy);
        end
        do_reset();
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h0 || busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL reset_pulse: got data=%h cnt=%0d want 0/0", rd_data[31:0], busy_cnt);
        end
    endtask

    task automatic test_byte_lanes();
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11223344; wr_byte_en = 4'hF;
        tick();
        wr_data = 32'hAABBCCDD; wr_byte_en = 4'b0101;
        tick();
        idle();
        rd_addr = {5'd0, 5'd7};
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h11BB33DD) begin
            n_err++; $display("FAIL byte_merge: got %h want 11bb33dd", rd_data[31:0]);
        end
        issue_en = 1'b1; issue_addr = 5'd7;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b1) begin
            n_err++; $display("FAIL issue_r7: got rd_busy=%b want 1", rd_busy[0]);
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = $urandom; wr_byte_en = 4'h0;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h11BB33DD || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL zero_be_write: got data=%h busy=%b cnt=%0d want 11bb33dd/0/0",
                              rd_data[31:0], rd_busy[0], busy_cnt);
        end
    endtask

    task automatic test_reg0();
        idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_byte_en = 4'hF;
        issue_en = 1'b1; issue_addr = 5'd0;
        tick();
        idle();
        rd_addr = {5'd0, 5'd0};
        #1;
        n_cmp++;
        if (rd_data !== '0) begin
            n_err++; $display("FAIL reg0_read: got %h want 0", rd_data);
        end
        n_cmp++;
        if (busy_vec[0] !== 1'b0 || busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL reg0_busy: got vec0=%b cnt=%0d want 0/0", busy_vec[0], busy_cnt);
        end
    endtask

    task automatic test_scoreboard();
        logic [31:0] d;
        do_reset();
        issue_en = 1'b1; issue_addr = 5'd3;
        tick();
        issue_addr = 5'd9;
        tick();
        idle();
        rd_addr = {5'd9, 5'd3};
        #1;
        n_cmp++;
        if (busy_cnt !== 6'd2 || rd_busy !== 2'b11) begin
            n_err++; $display("FAIL sb_two_issued: got cnt=%0d rd_busy=%b want 2/11", busy_cnt, rd_busy);
        end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = $urandom; wr_byte_en = 4'hF;
        issue_en = 1'b1; issue_addr = 5'd12;
        tick();
        idle();
        #1;
        n_cmp++;
        if (busy_cnt !== 6'd2 || busy_vec[3] !== 1'b0 || busy_vec[12] !== 1'b1 || rd_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL sb_swap: got cnt=%0d b3=%b b12=%b rd0=%b want 2/0/1/0",
                              busy_cnt, busy_vec[3], busy_vec[12], rd_busy[0]);
        end
        d = $urandom;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = d; wr_byte_en = 4'hF;
        issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        idle();
        #1;
        n_cmp++;
        if (busy_vec[9] !== 1'b1 || busy_cnt !== 6'd2 || rd_data[63:32] !== d) begin
            n_err++; $display("FAIL sb_set_clr_same: got b9=%b cnt=%0d data=%h want 1/2/%h",
                              busy_vec[9], busy_cnt, rd_data[63:32], d);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int r = 1; r < NREGS; r++) begin
            issue_en = 1'b1; issue_addr = AW'(r);
            tick();
        end
        idle();
        #1;
        n_cmp++;
        if (busy_cnt !== 6'd31 || sb_full !== 1'b1 || busy_vec !== 32'hFFFFFFFE) begin
            n_err++; $display("FAIL full_all: got cnt=%0d full=%b vec=%h want 31/1/fffffffe",
                              busy_cnt, sb_full, busy_vec);
        end
        issue_en = 1'b1; issue_addr = 5'd4;
        tick();
        idle();
        #1;
        n_cmp++;
        if (busy_cnt !== 6'd31 || sb_full !== 1'b1) begin
            n_err++; $display("FAIL full_reissue: got cnt=%0d full=%b want 31/1", busy_cnt, sb_full);
        end
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = $urandom; wr_byte_en = 4'hF;
        tick();
        idle();
        #1;
        n_cmp++;
        if (busy_cnt !== 6'd30 || sb_full !== 1'b0 || busy_vec[4] !== 1'b0) begin
            n_err++; $display("FAIL full_release: got cnt=%0d full=%b b4=%b want 30/0/0",
                              busy_cnt, sb_full, busy_vec[4]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        logic        exp_busy_same;
`ifdef GPR_BYPASS_EN
        exp_same      = 32'h00005678;
        exp_busy_same = 1'b0;
`else
        exp_same      = 32'h0;
        exp_busy_same = 1'b1;
`endif
        do_reset();
        issue_en = 1'b1; issue_addr = 5'd2;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h12345678; wr_byte_en = 4'b0011;
        rd_addr = {5'd2, 5'd1};
        #1;
        n_cmp++;
        if (rd_data[63:32] !== exp_same || rd_busy[1] !== exp_busy_same) begin
            n_err++; $display("FAIL bypass_same_cycle: got data=%h busy=%b want %h/%b",
                              rd_data[63:32], rd_busy[1], exp_same, exp_busy_same);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_data[63:32] !== 32'h00005678 || rd_busy[1] !== 1'b0) begin
            n_err++; $display("FAIL bypass_next_cycle: got data=%h busy=%b want 00005678/0",
                              rd_data[63:32], rd_busy[1]);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset      = ($urandom_range(0, 59) == 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            issue_en   = ($urandom_range(0, 3) != 0);
            wr_addr    = AW'((cyc % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
            issue_addr = AW'((cyc % 3 == 0) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
            wr_data    = $urandom;
            wr_byte_en = NL'($urandom);
            for (int k = 0; k < NR; k++) begin
                rd_addr[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? wr_addr
                                                                   : AW'($urandom_range(0, NREGS - 1));
            end
            #1;
            for (int k = 0; k < NR; k++) begin
                n_cmp++;
                if (rd_data[k*DW +: DW] !== exp_rd(k) || rd_busy[k] !== exp_rbusy(k)) begin
                    n_err++; $display("FAIL rand_port%0d cyc%0d: got data=%h busy=%b want %h/%b",
                                      k, cyc, rd_data[k*DW +: DW], rd_busy[k], exp_rd(k), exp_rbusy(k));
                end
            end
            n_cmp++;
            if (busy_vec !== model_vec() || int'(busy_cnt) != model_cnt() ||
                sb_full !== (model_cnt() == NREGS - 1)) begin
                n_err++; $display("FAIL rand_sb cyc%0d: got vec=%h cnt=%0d full=%b want %h/%0d/%b",
                                  cyc, busy_vec, busy_cnt, sb_full, model_vec(), model_cnt(),
                                  model_cnt() == NREGS - 1);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rd_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_byte_en = '0;
        issue_addr = '0;
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_basic_write();
        test_byte_lanes();
        test_reg0();
        test_scoreboard();
        test_full();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpr_multiport_sb.md
Name: gpr_multiport_sb

Overview:
- Parametrised successor to the single-write, two-read general-purpose register file.
- Adds N configurable read ports, per-byte write enables for any data width, and a per-register pending-write scoreboard (busy bits plus outstanding count) for pipeline hazard detection.
- Sits in the ID stage: issue logic marks destinations busy, and the WB stage writes back and clears them.
- Optional same-cycle write-to-read bypass.

Parameters:
- DATA_WIDTH, 32, register width; must be a multiple of 8.
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers.
- NUM_READ, 2, number of combinational read ports; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- rd_addr  input  NUM_READ*ADDR_WIDTH  packed read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  output  NUM_READ*DATA_WIDTH  packed read data, same packing.
- rd_busy  output  NUM_READ  per-port flag: addressed register has a pending write.
- wr_en  input  1  write-back strobe.
- wr_addr  input  ADDR_WIDTH  write-back register.
- wr_data  input  DATA_WIDTH  write-back data.
- wr_byte_en  input  DATA_WIDTH/8  byte lane enables; bit i covers bits [8i+7:8i].
- issue_en  input  1  mark issue_addr as pending.
- issue_addr  input  ADDR_WIDTH  destination being issued.
- busy_vec  output  2**ADDR_WIDTH  all busy bits.
- busy_cnt  output  ADDR_WIDTH+1  number of registers currently busy.
- sb_full  output  1  asserted when busy_cnt == 2**ADDR_WIDTH-1, i.e. all non-zero registers busy.

Behaviour:
- Reset, sampled on the rising edge:
  - All registers clear to 0 in a single cycle.
  - All busy bits clear to 0; busy_cnt = 0; sb_full = 0.
  - While reset is high, wr_en and issue_en are ignored.
  - rd_data reflects the cleared array from the next cycle.
- Register 0:
  - Always reads 0.
  - Writes to it are dropped.
  - issue to it is ignored; busy_vec[0] is constant 0.
- Write, on a rising edge when wr_en=1 and wr_addr!=0:
  - Each lane with wr_byte_en[i]=1 updates; other lanes hold.
  - wr_byte_en=0 with wr_en=1 leaves data unchanged but still clears the busy bit.
- Read:
  - Combinational: rd_data[k] = reg[rd_addr[k]].
  - Without bypass, a write becomes visible the cycle after its edge.
- Scoreboard, evaluated per register r!=0 each edge:
  - set = issue_en && issue_addr==r.
  - clr = wr_en && wr_addr==r.
  - set&&!clr -> busy=1; clr&&!set -> busy=0; set&&clr -> busy=1 (new producer wins, and the write still updates data); neither -> hold.
  - Issuing an already-busy register keeps it busy with no count change. There is no multi-producer count.
- busy_cnt:
  - Registered; equals popcount(busy_vec) at all times.
  - Updated incrementally: +1 on a 0->1 transition, -1 on a 1->0 transition, net 0 when both occur on different registers in the same cycle.
  - Must never wrap.
- rd_busy[k] = busy_vec[rd_addr[k]], combinational.
  - Without bypass, a clear takes effect the cycle after the edge.
- Mid-operation reset discards all pending busy state; no write completes on the reset edge.

Optional Feature:
- Macro: GPR_BYPASS_EN.
- Defined:
  - When wr_en=1, wr_addr!=0 and wr_addr==rd_addr[k], rd_data[k] merges wr_data per enabled byte lane with stored data for the other lanes, in the same cycle.
  - rd_busy[k] is forced 0 in that cycle unless issue_en targets the same register.
- Undefined: no forwarding; the read returns pre-write contents until the next edge.

Test Plan:
- Reset, write r5=0xDEADBEEF with byte_en=4'hF, then read port0=5 next cycle -> 0xDEADBEEF; pulse reset -> rd_data 0 and busy_cnt 0.
- r7=0x11223344, then write 0xAABBCCDD with byte_en=4'b0101 -> r7 reads 0x11BB33DD.
- Write 0xFFFFFFFF to r0 and issue r0 -> r0 reads 0, busy_vec[0]=0, busy_cnt=0.
- Issue r3, then r9 -> busy_cnt=2 and rd_busy=1 when reading r3. Same cycle: write r3 and issue r12 -> busy_cnt=2, r3 clear, r12 busy. Write r9 and issue r9 in the same cycle -> r9 stays busy, data updated, busy_cnt unchanged.
- Issue all of r1..r31 -> busy_cnt=31, sb_full=1. Issue r4 again -> count stays 31. Write r4 -> count 30, sb_full=0.
- With GPR_BYPASS_EN: r2=0x0, write r2=0x12345678 with byte_en=4'b0011 while port1 reads r2 -> 0x00005678 in the same cycle. Without the macro -> 0x0 that cycle, 0x00005678 the next.
